// File: rtl/life_render.sv
// life_render
//   Two-stage pixel renderer for a Game-of-Life board. Stage 1 classifies the
//   incoming pixel (inside the board, on the cursor cell, on the board edge)
//   and registers it together with the cell state and VGA timing. Stage 2
//   picks the colour and re-times the syncs so they stay aligned with rgb_out.
//   The block also counts live, visible, in-board pixels per frame and reports
//   the total on every falling edge of vsync. A frame counter blinks the cursor.
//
// Ports
//   clk_in                         pixel clock
//   rst_in                         asynchronous active-high reset
//   alive_in                       cell state for the current pixel
//   hcount_in, vcount_in           pixel coordinates, aligned with alive_in
//   hsync_in, vsync_in, blank_in   VGA timing (vsync active-low)
//   cursor_x_in, cursor_y_in       cursor cell position
//   rgb_out                        {R,G,B} 4 bits each, 2 cycles after input
//   hsync_out, vsync_out,
//   blank_out                      timing delayed to match rgb_out
//   pop_out                        live-cell count of the last completed frame
//   pop_valid_out                  one-cycle pulse when pop_out updates
module life_render #(
  parameter logic [11:0] ALIVE_COLOR    = 12'hFFF,
  parameter logic [11:0] DEAD_COLOR     = 12'h000,
  parameter logic [11:0] CURSOR_COLOR   = 12'hF00,
  parameter logic [11:0] BORDER_COLOR   = 12'h444,
  parameter int          BLINK_FRAMES   = 30,
  parameter int          HCOUNT_WIDTH   = 11,
  parameter int          VCOUNT_WIDTH   = 10,
  parameter int          LOG_BOARD_SIZE = 6,
  parameter int          BOARD_SIZE     = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      alive_in,
  input  logic [HCOUNT_WIDTH-1:0]   hcount_in,
  input  logic [VCOUNT_WIDTH-1:0]   vcount_in,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  input  logic                      blank_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_x_in,
  input  logic [LOG_BOARD_SIZE-1:0] cursor_y_in,
  output logic [11:0]               rgb_out,
  output logic                      hsync_out,
  output logic                      vsync_out,
  output logic                      blank_out,
  output logic [19:0]               pop_out,
  output logic                      pop_valid_out
);

  localparam logic [HCOUNT_WIDTH-1:0] BOARD_H   = HCOUNT_WIDTH'(BOARD_SIZE);
  localparam logic [VCOUNT_WIDTH-1:0] BOARD_V   = VCOUNT_WIDTH'(BOARD_SIZE);
  localparam logic [7:0]              BLINK_END = 8'(BLINK_FRAMES - 1);
  localparam logic [19:0]             POP_MAX   = 20'hFFFFF;

  // Stage 1 registers
  logic s1_in_board;
  logic s1_on_cursor;
  logic s1_on_border;
  logic s1_alive;
  logic s1_blank;
  logic s1_hsync;
  logic s1_vsync;   // doubles as the registered vsync used for edge detection

  // Frame-level state
  logic [7:0]  blink_cnt;
  logic        blink_on;
  logic [19:0] pop_acc;

  logic        frame_start;
  logic        pop_inc;
  logic [19:0] pop_acc_next;
  logic [11:0] color;

  // Stage 1 comparisons. Cursor coordinates are zero-extended; a cursor
  // outside the board is suppressed later by the in_board qualifier.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_in_board  <= 1'b0;
      s1_on_cursor <= 1'b0;
      s1_on_border <= 1'b0;
      s1_alive     <= 1'b0;
      s1_blank     <= 1'b1;
      s1_hsync     <= 1'b1;
      s1_vsync     <= 1'b1;
    end else begin
      s1_in_board  <= (hcount_in < BOARD_H) && (vcount_in < BOARD_V);
      s1_on_cursor <= (hcount_in == HCOUNT_WIDTH'(cursor_x_in)) &&
                      (vcount_in == VCOUNT_WIDTH'(cursor_y_in));
      s1_on_border <= ((hcount_in == BOARD_H) && (vcount_in <= BOARD_V)) ||
                      ((vcount_in == BOARD_V) && (hcount_in <= BOARD_H));
      s1_alive     <= alive_in;
      s1_blank     <= blank_in;
      s1_hsync     <= hsync_in;
      s1_vsync     <= vsync_in;
    end
  end

  // Stage 2 colour priority
  always_comb begin
    color = 12'h000;
    if (s1_blank) begin
      color = 12'h000;
    end else if (s1_on_cursor && s1_in_board && blink_on) begin
      color = CURSOR_COLOR;
    end else if (s1_in_board && s1_alive) begin
      color = ALIVE_COLOR;
    end else if (s1_in_board) begin
      color = DEAD_COLOR;
    end else if (s1_on_border) begin
      color = BORDER_COLOR;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rgb_out   <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
      blank_out <= 1'b1;
    end else begin
      rgb_out   <= color;
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
      blank_out <= s1_blank;
    end
  end

  // Falling vsync at the input marks the start of a new frame.
  assign frame_start = s1_vsync && !vsync_in;

  // Blink phase flips every BLINK_FRAMES frame starts.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      blink_cnt <= 8'd0;
      blink_on  <= 1'b1;
    end else if (frame_start) begin
      if (blink_cnt == BLINK_END) begin
        blink_cnt <= 8'd0;
        blink_on  <= !blink_on;
      end else begin
        blink_cnt <= blink_cnt + 8'd1;
      end
    end
  end

  // Population counter. The pixel held in stage 1 during the frame_start
  // cycle still belongs to the frame being closed, so it is folded into the
  // reported value before the accumulator clears.
  assign pop_inc      = s1_in_board && s1_alive && !s1_blank;
  assign pop_acc_next = (pop_inc && (pop_acc != POP_MAX)) ? pop_acc + 20'd1 : pop_acc;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pop_acc       <= 20'd0;
      pop_out       <= 20'd0;
      pop_valid_out <= 1'b0;
    end else begin
      pop_valid_out <= frame_start;
      if (frame_start) begin
        pop_out <= pop_acc_next;
        pop_acc <= 20'd0;
      end else begin
        pop_acc <= pop_acc_next;
      end
    end
  end

endmodule

// File: tb/tb_life_render.sv
module tb_life_render;

  localparam int BS  = 48;
  localparam int LOG = 6;
  localparam int HW  = 11;
  localparam int VW  = 10;
  localparam int BF  = 3;

  logic           clk;
  logic           rst;
  logic           alive_in;
  logic [HW-1:0]  hcount_in;
  logic [VW-1:0]  vcount_in;
  logic           hsync_in;
  logic           vsync_in;
  logic           blank_in;
  logic [LOG-1:0] cursor_x_in;
  logic [LOG-1:0] cursor_y_in;
  logic [11:0]    rgb_out;
  logic           hsync_out;
  logic           vsync_out;
  logic           blank_out;
  logic [19:0]    pop_out;
  logic           pop_valid_out;

  life_render #(
    .BLINK_FRAMES  (BF),
    .HCOUNT_WIDTH  (HW),
    .VCOUNT_WIDTH  (VW),
    .LOG_BOARD_SIZE(LOG),
    .BOARD_SIZE    (BS)
  ) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .alive_in     (alive_in),
    .hcount_in    (hcount_in),
    .vcount_in    (vcount_in),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .blank_in     (blank_in),
    .cursor_x_in  (cursor_x_in),
    .cursor_y_in  (cursor_y_in),
    .rgb_out      (rgb_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .blank_out    (blank_out),
    .pop_out      (pop_out),
    .pop_valid_out(pop_valid_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [14:0] exp_q[$];   // {rgb, hsync, vsync, blank}
  int          due_q[$];   // negedge cycle index at which exp_q entry is visible
  logic [19:0] pop_q[$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state
  bit     prev_vs = 1'b1;
  int     frames  = 0;
  longint acc_m   = 0;
  int     cur_x   = 0;
  int     cur_y   = 0;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_color(input int h, input int v, input bit a,
                                            input bit bl, input int cx, input int cy,
                                            input bit blink);
    bit in_board;
    in_board = (h < BS) && (v < BS);
    if (bl) return 12'h000;
    if (in_board && h == cx && v == cy && blink) return 12'hF00;
    if (in_board && a) return 12'hFFF;
    if (in_board) return 12'h000;
    if ((h == BS && v <= BS) || (v == BS && h <= BS)) return 12'h444;
    return 12'h000;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input int h, input int v, input bit a, input bit bl,
                       input bit hs, input bit vs);
    bit blink;
    @(negedge clk);
    hcount_in   = HW'(h);
    vcount_in   = VW'(v);
    alive_in    = a;
    blank_in    = bl;
    hsync_in    = hs;
    vsync_in    = vs;
    cursor_x_in = LOG'(cur_x);
    cursor_y_in = LOG'(cur_y);
    if (prev_vs && !vs) begin
      frames++;
      pop_q.push_back((acc_m > 64'hFFFFF) ? 20'hFFFFF : 20'(acc_m));
      acc_m = 0;
    end
    prev_vs = vs;
    blink = ((frames / BF) % 2) == 0;
    exp_q.push_back({ref_color(h, v, a, bl, cur_x, cur_y, blink), hs, vs, bl});
    due_q.push_back(cyc + 2);
    if (h < BS && v < BS && a && !bl) acc_m++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(BS + 5, BS + 5, 1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic vsync_pulse();
    drive(BS + 5, BS + 5, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(BS + 5, BS + 5, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
  endtask

  task automatic random_frame(input int n);
    int h, v;
    bit a;
    for (int i = 0; i < n; i++) begin
      h = $urandom_range(0, BS + 2);
      v = $urandom_range(0, BS + 2);
      a = (h < BS && v < BS) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 5) == 0) begin
        cur_x = (h < 64) ? h : $urandom_range(0, 63);
        cur_y = (v < 64) ? v : $urandom_range(0, 63);
      end
      drive(h, v, a, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 1'b1);
    end
    vsync_pulse();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rgb"},   20'(rgb_out), 20'h000);
    chk({tag, "_hsync"}, 20'(hsync_out), 20'd1);
    chk({tag, "_vsync"}, 20'(vsync_out), 20'd1);
    chk({tag, "_blank"}, 20'(blank_out), 20'd1);
    chk({tag, "_pop"},   pop_out, 20'd0);
    chk({tag, "_popv"},  20'(pop_valid_out), 20'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    due_q.delete();
    pop_q.delete();
    prev_vs = 1'b1;
    frames  = 0;
    acc_m   = 0;
  endtask

  // Asynchronous reset placed between clock edges.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs(tag);
    repeat (3) @(negedge clk);
    hcount_in = HW'(BS + 5);
    vcount_in = VW'(BS + 5);
    alive_in  = 1'b0;
    blank_in  = 1'b1;
    hsync_in  = 1'b1;
    vsync_in  = 1'b1;
    rst       = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        logic [14:0] e;
        int d;
        e = exp_q.pop_front();
        d = due_q.pop_front();
        if (d == cyc) begin
          chk("rgb",   20'(rgb_out),   20'(e[14:3]));
          chk("hsync", 20'(hsync_out), 20'(e[2]));
          chk("vsync", 20'(vsync_out), 20'(e[1]));
          chk("blank", 20'(blank_out), 20'(e[0]));
        end else begin
          chk("pixel_timing", 20'(cyc), 20'(d));
        end
      end
      if (pop_valid_out) begin
        if (pop_q.size() == 0) chk("pop_valid_extra", 20'd1, 20'd0);
        else chk("pop_out", pop_out, pop_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    alive_in    = 1'b0;
    hcount_in   = '0;
    vcount_in   = '0;
    hsync_in    = 1'b1;
    vsync_in    = 1'b1;
    blank_in    = 1'b1;
    cursor_x_in = '0;
    cursor_y_in = '0;
    #1;
    check_reset_outputs("reset_init");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single live pixel with neighbours, cursor parked at (0,0)
    cur_x = 0; cur_y = 0;
    drive(4, 7, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(5, 7, 1'b1, 1'b0, 1'b0, 1'b1);
    drive(6, 7, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(5, 7, 1'b1, 1'b1, 1'b1, 1'b1);

    // Cursor on the live cell, then blink phases
    cur_x = 5; cur_y = 7;
    drive(5, 7, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(5, 7, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int f = 0; f < 2 * BF; f++) begin
      vsync_pulse();
      drive(5, 7, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(4, 7, 1'b1, 1'b0, 1'b1, 1'b1);
    end

    // Board edge, beyond it, blanking, out-of-board cursor
    drive(BS, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(BS + 1, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(3, BS, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(BS, BS, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(BS + 1, BS, 1'b0, 1'b0, 1'b1, 1'b1);
    cur_x = BS + 2; cur_y = 3;
    drive(BS + 2, 3, 1'b0, 1'b0, 1'b1, 1'b1);
    cur_x = 2; cur_y = BS;
    drive(2, BS, 1'b0, 1'b0, 1'b1, 1'b1);
    vsync_pulse();

    // Frame with 37 live in-board pixels, then an empty frame
    cur_x = 63; cur_y = 63;
    for (int i = 0; i < 37; i++) begin
      drive(i, 10, 1'b1, 1'b0, 1'b1, 1'b1);
      drive(i, 11, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    vsync_pulse();
    for (int i = 0; i < 20; i++) drive(i, 12, 1'b0, 1'b0, 1'b1, 1'b1);
    vsync_pulse();

    // Mid-frame asynchronous reset discards the partial count
    for (int i = 0; i < 10; i++) drive(i, 20, 1'b1, 1'b0, 1'b1, 1'b1);
    async_reset("reset_mid");
    for (int i = 0; i < 4; i++) drive(i, 21, 1'b1, 1'b0, 1'b1, 1'b1);
    drive(8, 21, 1'b0, 1'b0, 1'b1, 1'b1);
    vsync_pulse();

    // Saturation of the population counter
    drive(1, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(2, 1, 1'b0, 1'b0, 1'b1, 1'b1);
    force dut.pop_acc = 20'hFFFFE;
    acc_m = 20'hFFFFE;
    #1;
    release dut.pop_acc;
    for (int i = 0; i < 3; i++) drive(i, 30, 1'b1, 1'b0, 1'b1, 1'b1);
    vsync_pulse();

    // Randomised frames
    for (int f = 0; f < 12; f++) random_frame($urandom_range(40, 200));

    idle(4);
    repeat (4) @(negedge clk);
    chk("exp_q_drained", 20'(exp_q.size()), 20'd0);
    chk("pop_q_drained", 20'(pop_q.size()), 20'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
